// File: rtl/wash_pkg.sv
// Shared types and helpers for the wash front-panel controller.
package wash_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        RUN   = 3'd2,
        ABORT = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } wash_state_t;

    // Wash mode codes presented to the machine.
    localparam logic [1:0] MODE_0 = 2'd0;
    localparam logic [1:0] MODE_1 = 2'd1;
    localparam logic [1:0] MODE_2 = 2'd2;
    localparam logic [1:0] MODE_3 = 2'd3;

    // Width of a counter able to hold the largest of three cycle counts,
    // with one spare bit so the terminal value never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Registered rising-edge detector for one panel key.
module key_edge (
    input  logic clk,
    input  logic srst,
    input  logic key,
    output logic edge_pulse
);

    logic key_q_reg;

    // Key history; a held key yields one event since key_q follows it.
    always_ff @(posedge clk) begin
        if (srst) key_q_reg <= 1'b0;
        else      key_q_reg <= key;
    end

    assign edge_pulse = key & ~key_q_reg;

endmodule

// File: rtl/wash_panel_ctrl.sv
// Front-panel initiator for the 4-mode washing machine: key handling,
// start/abort sequencing, timeout watchdog and status outputs.
module wash_panel_ctrl
    import wash_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ABORT_CYCLES   = 2,
    parameter int DONE_HOLD      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_start,
    input  logic       key_cancel,
    input  logic       mc_done,
    output logic       mc_start,
    output logic [1:0] mc_mode,
    output logic       mc_rst,
    output logic [1:0] sel_mode,
    output logic       busy,
    output logic       done_led,
    output logic       error
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES, ABORT_CYCLES, DONE_HOLD);

    localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] ABORT_LOAD = CW'(ABORT_CYCLES - 1);
    localparam logic [CW-1:0] DONE_LOAD  = CW'(DONE_HOLD - 1);

    // Key index order within the edge vector.
    localparam int K_MODE   = 0;
    localparam int K_START  = 1;
    localparam int K_CANCEL = 2;

    logic [2:0] keys;
    logic [2:0] key_edges;

    wash_state_t state_reg, state_next;
    logic [1:0]    sel_mode_reg, sel_mode_next;
    logic [1:0]    mc_mode_reg, mc_mode_next;
    logic [CW-1:0] timer_reg, timer_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          fault_rst_reg, fault_rst_next;

    assign keys = {key_cancel, key_start, key_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            key_edge u_key_edge (
                .clk        (clk),
                .srst       (rst),
                .key        (keys[gi]),
                .edge_pulse (key_edges[gi])
            );
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sel_mode_reg  <= MODE_0;
            mc_mode_reg   <= MODE_0;
            timer_reg     <= '0;
            cnt_reg       <= '0;
            fault_rst_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_mode_reg  <= sel_mode_next;
            mc_mode_reg   <= mc_mode_next;
            timer_reg     <= timer_next;
            cnt_reg       <= cnt_next;
            fault_rst_reg <= fault_rst_next;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_next     = state_reg;
        sel_mode_next  = sel_mode_reg;
        mc_mode_next   = mc_mode_reg;
        timer_next     = timer_reg;
        cnt_next       = cnt_reg;
        fault_rst_next = fault_rst_reg;

        mc_start = 1'b0;
        mc_rst   = 1'b0;
        busy     = 1'b0;
        done_led = 1'b0;
        error    = 1'b0;

        case (state_reg)
            IDLE: begin
                // A simultaneous start uses the pre-increment selection.
                if (key_edges[K_MODE])
                    sel_mode_next = sel_mode_reg + 2'd1;
                if (key_edges[K_START]) begin
                    mc_mode_next = sel_mode_reg;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                mc_start   = 1'b1;
                busy       = 1'b1;
                timer_next = '0;
                state_next = RUN;
            end
            RUN: begin
                mc_start   = 1'b1;
                busy       = 1'b1;
                timer_next = timer_reg + 1'b1;
                if (mc_done) begin
                    cnt_next   = DONE_LOAD;
                    state_next = DONE;
                end else if (key_edges[K_CANCEL]) begin
                    cnt_next   = ABORT_LOAD;
                    state_next = ABORT;
                end else if (timer_reg == TIMER_LAST) begin
                    cnt_next       = ABORT_LOAD;
                    fault_rst_next = 1'b1;
                    state_next     = FAULT;
                end
            end
            ABORT: begin
                mc_rst = 1'b1;
                busy   = 1'b1;
                if (cnt_reg == '0) state_next = IDLE;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            DONE: begin
                done_led = 1'b1;
                if (cnt_reg == '0) state_next = IDLE;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            FAULT: begin
                error  = 1'b1;
                mc_rst = fault_rst_reg;
                // Abort pulse to the machine runs first; error then latches.
                if (fault_rst_reg) begin
                    if (cnt_reg == '0) fault_rst_next = 1'b0;
                    else               cnt_next       = cnt_reg - 1'b1;
                end
                if (key_edges[K_CANCEL]) begin
                    fault_rst_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sel_mode = sel_mode_reg;
    assign mc_mode  = mc_mode_reg;

endmodule

// File: doc/wash_panel_ctrl.md
Name: wash_panel_ctrl

Overview:
- Front-panel controller that acts as the initiator for the 4-mode washing machine FSM.
- Turns user key presses into the machine's start/mode/abort signals and waits for the machine's completion output.
- Supervises each cycle with a timeout watchdog and drives panel status outputs.
- Sits between the panel keys and the washing machine block at the top level.

Parameters:
- TIMEOUT_CYCLES, 64: maximum clk cycles spent in RUN before a fault is declared.
- ABORT_CYCLES, 2: number of cycles mc_rst is held high on cancel or fault.
- DONE_HOLD, 4: number of cycles done_led stays high after completion.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- key_mode  input  1  mode-select key, level; each rising edge advances the mode.
- key_start  input  1  start key, level.
- key_cancel  input  1  cancel key, level.
- mc_done  input  1  completion output from the washing machine.
- mc_start  output  1  start request to the machine.
- mc_mode  output  2  mode to the machine (0..3).
- mc_rst  output  1  abort pulse to the machine.
- sel_mode  output  2  currently selected mode, for display.
- busy  output  1  high while a wash is in progress.
- done_led  output  1  completion indicator.
- error  output  1  timeout fault indicator.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; sel_mode=0, mc_mode=0, timer=0.
  - Key history registers are cleared to 0.
  - All 1-bit outputs are 0.
- Key edge detection: edge = key & ~key_q, with key_q registered every cycle. A key held high produces exactly one event.
- Outputs are Moore, decoded from registered state:
  - mc_start=1 in ISSUE and RUN.
  - busy=1 in ISSUE, RUN and ABORT.
  - mc_rst=1 in ABORT and in FAULT while the abort counter runs.
  - done_led=1 in DONE.
  - error=1 in FAULT.
- IDLE:
  - A mode edge sets sel_mode=sel_mode+1 modulo 4 (3 wraps to 0).
  - A start edge latches mc_mode<=sel_mode and moves to ISSUE.
  - If mode and start edges arrive in the same cycle, the start uses the old sel_mode; sel_mode still increments.
  - Cancel is ignored.
- ISSUE: lasts one cycle. Clears timer, then moves to RUN. mc_start goes high the cycle after the start edge.
- RUN:
  - timer increments every cycle.
  - Priority, highest first: (1) mc_done=1 goes to DONE; (2) cancel edge goes to ABORT; (3) timer==TIMEOUT_CYCLES-1 goes to FAULT.
  - Mode and start edges are ignored; mc_mode stays stable.
- ABORT: mc_rst is held for ABORT_CYCLES cycles, then the block returns to IDLE. Keys are ignored.
- DONE: done_led is held for DONE_HOLD cycles, then the block returns to IDLE. Keys are ignored.
- FAULT:
  - mc_rst is asserted for ABORT_CYCLES cycles.
  - error stays high until a cancel edge, then the block returns to IDLE. Other keys are ignored.
- A single down-counter is shared by ABORT, DONE and the FAULT abort phase. Its width is $clog2 of the largest of the three parameters, plus 1.
- mc_done is accepted only in RUN and ignored elsewhere.
- rst mid-operation forces IDLE on the next edge, with all outputs as at reset. mc_rst is not pulsed, because the machine shares rst.

Decomposition:
- wash_pkg holds:
  - the state encoding: IDLE, ISSUE, RUN, ABORT, DONE, FAULT;
  - the mode constants MODE_0..MODE_3 (2 bits);
  - a function that computes counter width.
- One natural sub-module, key_edge: a registered rising-edge detector with clk/rst. It is instantiated three times, once per key.

Test Plan:
1. Reset, then 5 mode edges -> sel_mode reads 1,2,3,0,1 (wrap at 3).
2. sel_mode=2, start edge at cycle N -> mc_start=1 and mc_mode=2 from N+1. mc_done at N+10 -> done_led high exactly 4 cycles, then IDLE with busy=0.
3. key_start held high 20 cycles during IDLE/RUN -> exactly one ISSUE. Mode edges during RUN leave mc_mode=2 and sel_mode unchanged.
4. In RUN, cancel edge -> mc_rst high exactly 2 cycles, then IDLE. Cancel and mc_done in the same cycle -> DONE is taken and mc_rst stays 0.
5. No mc_done, TIMEOUT_CYCLES=64 -> FAULT entered after 64 RUN cycles. mc_rst pulses 2 cycles and error stays high until a cancel edge, then IDLE with error=0.
6. rst asserted mid-RUN -> next cycle all outputs are 0, sel_mode=0, and the next start begins with mode 0.
